// File: rtl/keccak_pkg.sv
// Shared types and sizes for the Keccak lane collector and its consumers.
package keccak_pkg;

    localparam int unsigned LANE_W  = 64;
    localparam int unsigned NLANES  = 25;
    localparam int unsigned STATE_W = LANE_W * NLANES;

    typedef logic [LANE_W-1:0]  lane_t;
    typedef logic [STATE_W-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } coll_st_e;

endpackage

// File: rtl/keccak_lane_collector.sv
// Assembles 25 pushed 64-bit lanes into one 1600-bit Keccak state block and
// hands it to the permutation over a valid/ready handshake.
module keccak_lane_collector
    import keccak_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pushin,
    input  logic                 firstin,
    input  logic [LANE_W-1:0]    din,
    output logic                 stopin,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [STATE_W-1:0]   blk,
    output logic [IDX_W-1:0]     lane_idx,
    output logic                 err_frame,
    output logic                 err_ovf
);

    localparam int unsigned BASE_W = $clog2(STATE_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLANES - 1);

    coll_st_e            st, st_d;
    logic                stop_d, valid_d, errf_d, ovf_d;
    logic [IDX_W-1:0]    idx_d, wr_idx;
    logic                lane_we;
    logic                accept;
    logic [BASE_W-1:0]   wr_base;

    assign accept  = pushin && !stopin;
    assign wr_base = BASE_W'(wr_idx) * BASE_W'(LANE_W);

    // State and registered outputs; blk keeps old lanes until overwritten.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= IDLE;
            stopin    <= 1'b0;
            blk_valid <= 1'b0;
            blk       <= '0;
            lane_idx  <= '0;
            err_frame <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            st        <= st_d;
            stopin    <= stop_d;
            blk_valid <= valid_d;
            lane_idx  <= idx_d;
            err_frame <= errf_d;
            err_ovf   <= ovf_d;
            if (lane_we) begin
                blk[wr_base +: LANE_W] <= din;
            end
        end
    end

    // Next-state, lane write decode and flag updates.
    always_comb begin
        st_d    = st;
        stop_d  = stopin;
        valid_d = blk_valid;
        idx_d   = lane_idx;
        errf_d  = 1'b0;
        ovf_d   = err_ovf;
        lane_we = 1'b0;
        wr_idx  = lane_idx;

        if (pushin && stopin) begin
            ovf_d = 1'b1;
        end

        unique case (st)
            IDLE: begin
                if (accept && firstin) begin
                    lane_we = 1'b1;
                    wr_idx  = '0;
                    idx_d   = IDX_W'(1);
                    st_d    = FILL;
                end else if (accept) begin
                    errf_d = 1'b1;
                end
            end
            FILL: begin
                if (accept && firstin) begin
                    // Early restart: the partial block is abandoned in place.
                    errf_d  = 1'b1;
                    lane_we = 1'b1;
                    wr_idx  = '0;
                    idx_d   = IDX_W'(1);
                end else if (accept) begin
                    lane_we = 1'b1;
                    if (lane_idx == LAST_IDX) begin
                        idx_d   = '0;
                        valid_d = 1'b1;
                        stop_d  = 1'b1;
                        st_d    = FULL;
                    end else begin
                        idx_d = lane_idx + IDX_W'(1);
                    end
                end
            end
            FULL: begin
                if (blk_ready) begin
                    valid_d = 1'b0;
                    stop_d  = 1'b0;
                    st_d    = IDLE;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_keccak_lane_collector.sv
// Directed scoreboard bench for keccak_lane_collector.
module tb_keccak_lane_collector;
    import keccak_pkg::*;

    logic           clk;
    logic           reset;
    logic           pushin;
    logic           firstin;
    lane_t          din;
    logic           stopin;
    logic           blk_valid;
    logic           blk_ready;
    state_t         blk;
    logic [5:0]     lane_idx;
    logic           err_frame;
    logic           err_ovf;

    int             total;
    int             bad;
    int             cyc;
    int             errf_cnt;
    state_t         exp_q[$];
    int             hs_cyc[$];

    keccak_lane_collector #(.IDX_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .pushin    (pushin),
        .firstin   (firstin),
        .din       (din),
        .stopin    (stopin),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk       (blk),
        .lane_idx  (lane_idx),
        .err_frame (err_frame),
        .err_ovf   (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_blk(input string nm, input state_t act, input state_t exp);
        int first_bad;
        first_bad = -1;
        for (int i = NLANES - 1; i >= 0; i--) begin
            if (act[i*LANE_W +: LANE_W] !== exp[i*LANE_W +: LANE_W]) first_bad = i;
        end
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL %s: lane %0d got %h expected %h (t=%0t)", nm, first_bad,
                     act[first_bad*LANE_W +: LANE_W], exp[first_bad*LANE_W +: LANE_W], $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends a full 25-lane block; lane i = base+i when inc, else base.
    task automatic send_block(input lane_t base, input bit inc, input bit expect_errf);
        state_t e;
        lane_t  d;
        e = '0;
        for (int i = 0; i < int'(NLANES); i++) begin
            d = inc ? base + lane_t'(i) : base;
            e[i*LANE_W +: LANE_W] = d;
            if (i == int'(NLANES) - 1) begin
                chk("valid_before_last_lane", 64'(blk_valid), 64'd0);
                chk("idx_before_last_lane", 64'(lane_idx), 64'd24);
            end
            pushin  = 1'b1;
            firstin = (i == 0);
            din     = d;
            tick();
            if (i == 0) chk("errf_after_first_lane", 64'(err_frame), 64'(expect_errf));
        end
        pushin  = 1'b0;
        firstin = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic send_partial(input lane_t base, input int n);
        for (int i = 0; i < n; i++) begin
            pushin  = 1'b1;
            firstin = (i == 0);
            din     = base + lane_t'(i);
            tick();
        end
        pushin  = 1'b0;
        firstin = 1'b0;
    endtask

    task automatic handshake();
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
    endtask

    initial begin
        int errf0;
        int hs0;
        total = 0; bad = 0; cyc = 0; errf_cnt = 0;
        reset = 1'b0; pushin = 1'b0; firstin = 1'b0; din = '0; blk_ready = 1'b0;

        // Monitor: pops the scoreboard on every accepted block.
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (err_frame) errf_cnt++;
                if (reset && blk_valid && blk_ready) begin
                    hs_cyc.push_back(cyc);
                    chk("scoreboard_nonempty", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) chk_blk("blk_data", blk, exp_q.pop_front());
                end
            end
        join_none

        tick(); tick();
        reset = 1'b1;
        tick();
        chk("rst_stopin", 64'(stopin), 64'd0);
        chk("rst_valid", 64'(blk_valid), 64'd0);
        chk("rst_blk_lane0", blk[63:0], 64'd0);
        chk("rst_idx", 64'(lane_idx), 64'd0);
        chk("rst_errf", 64'(err_frame), 64'd0);
        chk("rst_ovf", 64'(err_ovf), 64'd0);

        // Nominal block, lane i = i, held until ready.
        send_block(64'd0, 1'b1, 1'b0);
        chk("nom_valid", 64'(blk_valid), 64'd1);
        chk("nom_stopin", 64'(stopin), 64'd1);
        chk("nom_idx_wrap", 64'(lane_idx), 64'd0);
        tick(); tick(); tick();
        chk("nom_valid_held", 64'(blk_valid), 64'd1);
        handshake();
        chk("nom_valid_drop", 64'(blk_valid), 64'd0);
        chk("nom_stopin_drop", 64'(stopin), 64'd0);

        // Back-to-back with ready tied high.
        blk_ready = 1'b1;
        send_block(64'h1111_0000_0000_0000, 1'b1, 1'b0);
        tick();
        chk("b2b_stopin_bubble", 64'(stopin), 64'd0);
        send_block(64'hA5A5_0000_0000_0000, 1'b1, 1'b0);
        tick();
        blk_ready = 1'b0;
        chk("b2b_valid_pulse_end", 64'(blk_valid), 64'd0);
        chk("b2b_spacing", 64'(hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2]), 64'd26);

        // Early restart after 10 lanes.
        errf0 = errf_cnt;
        send_partial(64'h7777, 10);
        chk("rst_partial_idx", 64'(lane_idx), 64'd10);
        send_block(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        handshake();
        chk("restart_errf_count", 64'(errf_cnt - errf0), 64'd1);

        // Headless pushes from IDLE.
        errf0 = errf_cnt;
        hs0 = hs_cyc.size();
        for (int k = 0; k < 3; k++) begin
            pushin = 1'b1; firstin = 1'b0; din = lane_t'(64'h55 + k);
            tick();
            chk("headless_errf", 64'(err_frame), 64'd1);
            chk("headless_idx", 64'(lane_idx), 64'd0);
        end
        pushin = 1'b0;
        tick();
        chk("headless_errf_count", 64'(errf_cnt - errf0), 64'd3);
        chk("headless_no_valid", 64'(blk_valid), 64'd0);
        chk("headless_no_hs", 64'(hs_cyc.size() - hs0), 64'd0);

        // Overflow while a block is pending.
        chk("ovf_clear_before", 64'(err_ovf), 64'd0);
        send_block(64'h100, 1'b1, 1'b0);
        pushin = 1'b1; firstin = 1'b0; din = 64'hDEAD_BEEF;
        tick();
        pushin = 1'b0;
        chk("ovf_set", 64'(err_ovf), 64'd1);
        chk("ovf_stopin", 64'(stopin), 64'd1);
        chk_blk("ovf_blk_held", blk, exp_q[exp_q.size()-1]);
        tick();
        handshake();
        send_block(64'h200, 1'b1, 1'b0);
        handshake();
        chk("ovf_sticky", 64'(err_ovf), 64'd1);

        // Reset in the middle of a fill.
        send_partial(64'h7000, 13);
        reset = 1'b0;
        #1;
        chk("arst_stopin", 64'(stopin), 64'd0);
        chk("arst_valid", 64'(blk_valid), 64'd0);
        chk_blk("arst_blk", blk, '0);
        chk("arst_idx", 64'(lane_idx), 64'd0);
        chk("arst_errf", 64'(err_frame), 64'd0);
        chk("arst_ovf", 64'(err_ovf), 64'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        send_block(64'h300, 1'b1, 1'b0);
        handshake();

        tick(); tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("handshake_count", 64'(hs_cyc.size()), 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keccak_lane_collector.md
Name: keccak_lane_collector

Overview:
- Upstream feeder for the 1600-bit Keccak permutation stage.
- Accepts a 64-bit lane push stream framed by `firstin` and assembles 25 lanes (x+5y order) into one 1600-bit state block.
- Presents the block to the permutation with a valid/ready handshake and applies backpressure upstream until the block is taken.
- Detects and flags framing errors (missing or early `firstin`, push while stalled).

Parameters:
- LANE_W, 64, lane width in bits
- NLANES, 25, lanes per block
- IDX_W, 6, width of the lane index counter (must satisfy 2^IDX_W > NLANES)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- pushin  in  1  input lane valid
- firstin  in  1  qualifies the lane on `din` as lane 0 of a new block; meaningful only with `pushin`=1
- din  in  64  input lane data
- stopin  out  1  backpressure to upstream; a push in a cycle with `stopin`=1 is not accepted
- blk_valid  out  1  `blk` holds a complete block
- blk_ready  in  1  permutation accepts `blk` this cycle when `blk_valid`=1
- blk  out  1600  assembled state; lane i at bits [64*i+63:64*i]
- lane_idx  out  6  index of the next lane to be written (0..24)
- err_frame  out  1  one-cycle pulse on a framing error
- err_ovf  out  1  sticky flag; a push was dropped while `stopin`=1; cleared only by reset

Behaviour:
- All outputs are registered. Reset values: `stopin`=0, `blk_valid`=0, `blk`=0, `lane_idx`=0, `err_frame`=0, `err_ovf`=0. State is IDLE.
- A push is accepted when `pushin`=1 and `stopin`=0 in the same cycle.
- State IDLE (waiting for frame start):
  - Accepted push with `firstin`=1: write `din` to lane 0, set `lane_idx`=1, go to FILL.
  - Accepted push with `firstin`=0: data is discarded, pulse `err_frame`, stay in IDLE.
- State FILL:
  - Accepted push with `firstin`=0: write lane `lane_idx`, then increment it.
  - When lane 24 is written: next cycle `blk_valid`=1, `stopin`=1, `lane_idx`=0, go to FULL. The latency from the last accepted lane to `blk_valid` is exactly 1 cycle.
  - Accepted push with `firstin`=1 (early restart): pulse `err_frame`, discard the partial block, write `din` to lane 0, set `lane_idx`=1, stay in FILL.
- State FULL:
  - `blk` is held stable while `blk_valid`=1.
  - When `blk_ready`=1: next cycle `blk_valid`=0, `stopin`=0, go to IDLE.
  - The cycle after acceptance is already a legal push cycle, so back-to-back blocks need only 1 bubble cycle.
- `stopin` equals 1 exactly when the state is FULL.
- `pushin`=1 while `stopin`=1: data is dropped, `err_ovf` is set, state is unchanged.
- `blk` contents are not cleared between blocks. Unwritten lanes of a restarted block are always overwritten before `blk_valid` rises, because the block is only released after all 25 lanes are written in order.
- Reset asserted mid-operation: outputs return to their reset values immediately (asynchronous); any partial block and any pending block are lost.
- `lane_idx` never exceeds 24. It wraps to 0 on block completion or restart.

Decomposition:
- Shared package `keccak_pkg` holds:
  - `LANE_W`, `NLANES`, `STATE_W` (=1600)
  - typedef `lane_t` (logic [63:0])
  - typedef `state_t` (logic [1599:0])
  - enum `coll_st_e` {IDLE, FILL, FULL}
- No sub-module is needed. Lane write decode is a single indexed part-select inside the block.

Test Plan:
- Nominal block: `firstin` with `din`=64'h0, then 24 pushes with `din`=lane index (1..24), `blk_ready`=0. Expect `blk_valid`=1 one cycle after lane 24, `blk[64*i+:64]`=i for all i, and `stopin`=1. Assert `blk_ready`; the next cycle `blk_valid`=0 and `stopin`=0.
- Back-to-back: two blocks with `blk_ready` tied 1. Expect two `blk_valid` single-cycle pulses separated by 25 accept cycles + 1 bubble, second block data 64'hA5A5_0000_0000_0000+i intact.
- Early restart: `firstin` + 10 lanes, then `firstin` + 25 lanes of 64'hFFFF_FFFF_FFFF_FFFF. Expect an `err_frame` pulse in the cycle after the restart push, and the delivered block is all ones.
- Headless push: 3 pushes with `firstin`=0 from IDLE. Expect 3 `err_frame` pulses, `lane_idx` stays 0, and no `blk_valid`.
- Overflow: complete a block, hold `blk_ready`=0, push `din`=64'hDEAD_BEEF. Expect `err_ovf`=1 (sticky), `blk` unchanged, and a subsequent block still correct.
- Reset mid-fill: drive `reset`=0 after lane 12 of a block. Expect all outputs at reset values asynchronously, and the next `firstin` starts a fresh block at lane 0.
